// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU op-code encoding, controller state type and op-class helpers.
package mdu_pkg;
    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_MULT, ST_DIV} mdu_state_t;

    function automatic logic is_mult_op(input logic [3:0] op);
        return op == OP_MULT || op == OP_MULTU;
    endfunction

    function automatic logic is_start_op(input logic [3:0] op);
        return is_mult_op(op) || op == OP_DIV || op == OP_DIVU;
    endfunction
endpackage

// File: rtl/mdu_latency_counter.sv
// mdu_latency_counter: loadable 4-bit down-counter with zero detect for MDU latency.
module mdu_latency_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);
    logic [3:0] cnt;
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= 4'd0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end
    assign zero = cnt == 4'd0;
endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issues E-stage MDU ops, tracks mult/div busy and stalls D-stage MDU users.
// Define MDU_ISSUE_PERF_EN to add the saturating stall_cycles performance counter.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       e_valid,
    input  logic [3:0] e_op,
    input  logic       d_md_use,
    output logic [3:0] mdu_op,
    output logic       mdu_start,
    output logic       mdu_busy,
    output logic       stall_d,
    output logic       proto_err
`ifdef MDU_ISSUE_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    mdu_state_t state;
    logic       active, issue, cnt_zero;

    // Outputs are masked by reset so nothing leaks out while state is being cleared.
    assign active    = state != ST_IDLE;
    assign issue     = e_valid & !req & !active & !reset;
    assign mdu_op    = issue ? e_op : OP_NONE;
    assign mdu_start = issue & is_start_op(e_op);
    assign mdu_busy  = active & !reset;
    assign stall_d   = d_md_use & (mdu_busy | mdu_start);

    mdu_latency_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (mdu_start),
        .load_val (is_mult_op(e_op) ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1)),
        .en       (active),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            proto_err <= 1'b0;
        end else begin
            if (mdu_start)
                state <= is_mult_op(e_op) ? ST_MULT : ST_DIV;
            else if (active && cnt_zero)
                state <= ST_IDLE;
            if (active && e_valid && is_start_op(e_op))
                proto_err <= 1'b1;
        end
    end

`ifdef MDU_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= 32'd0;
        else if (stall_d && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: directed scoreboard bench for mdu_issue_ctrl.
module tb_mdu_issue_ctrl;
    logic       clk = 1'b0;
    logic       reset, req, e_valid, d_md_use;
    logic [3:0] e_op;
    logic [3:0] mdu_op;
    logic       mdu_start, mdu_busy, stall_d, proto_err;
`ifdef MDU_ISSUE_PERF_EN
    logic [31:0] stall_cycles;
`endif
    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       start;
        logic [3:0] op;
        logic       busy;
        logic       stall;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .e_valid   (e_valid),
        .e_op      (e_op),
        .d_md_use  (d_md_use),
        .mdu_op    (mdu_op),
        .mdu_start (mdu_start),
        .mdu_busy  (mdu_busy),
        .stall_d   (stall_d),
        .proto_err (proto_err)
`ifdef MDU_ISSUE_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare at the falling edge.
    task automatic step(input string tag, input logic v, input logic [3:0] op, input logic r,
                        input logic d, input logic rs, input logic es, input logic [3:0] eop,
                        input logic eb, input logic est);
        exp_t e;
        e_valid = v; e_op = op; req = r; d_md_use = d; reset = rs;
        sb.push_back('{tag, es, eop, eb, est});
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, ".start"}, 32'(mdu_start), 32'(e.start));
        chk({e.tag, ".op"},    32'(mdu_op),    32'(e.op));
        chk({e.tag, ".busy"},  32'(mdu_busy),  32'(e.busy));
        chk({e.tag, ".stall"}, 32'(stall_d),   32'(e.stall));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; e_valid = 1'b0; e_op = 4'd0; d_md_use = 1'b0;
        @(posedge clk);
        #1;
        step("rst_mask", 1, 4'd1, 0, 1, 1, 0, 4'd0, 0, 0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        // MULT at cycle 0 with D-stage MDU user
        step("mult_c0", 1, 4'd1, 0, 1, 0, 1, 4'd1, 0, 1);
        for (int i = 1; i <= 5; i++)
            step($sformatf("mult_c%0d", i), 0, 4'd0, 0, 1, 0, 0, 4'd0, 1, 1);
        step("mult_c6", 0, 4'd0, 0, 1, 0, 0, 4'd0, 0, 0);
`ifdef MDU_ISSUE_PERF_EN
        chk("perf_mult", stall_cycles, 32'd6);
`endif
        // DIVU cancelled by req, then accepted
        step("divu_req", 1, 4'd4, 1, 0, 0, 0, 4'd0, 0, 0);
        step("divu_req_idle", 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
        step("divu_c0", 1, 4'd4, 0, 0, 0, 1, 4'd4, 0, 0);
        for (int i = 1; i <= 10; i++)
            step($sformatf("divu_c%0d", i), 0, 4'd0, i == 3, 0, 0, 0, 4'd0, 1, 0);
        // back-to-back MULT on the first idle cycle; a second MULT offered while busy
        step("b2b_mult", 1, 4'd2, 0, 1, 0, 1, 4'd2, 0, 1);
        step("b2b_c1", 0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0);
        chk("perr_before", 32'(proto_err), 32'd0);
        step("busy_mult", 1, 4'd1, 0, 1, 0, 0, 4'd0, 1, 1);
        chk("perr_set", 32'(proto_err), 32'd1);
        for (int i = 3; i <= 5; i++)
            step($sformatf("b2b_c%0d", i), 0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0);
        step("b2b_c6", 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
        // move-to-HI passes op only
        step("mthi", 1, 4'd7, 0, 1, 0, 0, 4'd7, 0, 0);
        step("mthi_next", 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
        step("mflo", 1, 4'd6, 0, 0, 0, 0, 4'd6, 0, 0);
        chk("perr_held", 32'(proto_err), 32'd1);
        // reset in the middle of a DIV
        step("div_c0", 1, 4'd3, 0, 0, 0, 1, 4'd3, 0, 0);
        step("div_c1", 0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0);
        step("div_c2", 0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0);
        step("div_rst", 0, 4'd0, 0, 1, 1, 0, 4'd0, 0, 0);
        step("div_after", 0, 4'd0, 0, 1, 0, 0, 4'd0, 0, 0);
        chk("perr_clr", 32'(proto_err), 32'd0);
`ifdef MDU_ISSUE_PERF_EN
        chk("perf_clr", stall_cycles, 32'd0);
`endif
        step("div_fresh", 1, 4'd3, 0, 0, 0, 1, 4'd3, 0, 0);
        step("div_fresh_c1", 0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
